// File: rtl/qbus_master.sv
// Q-bus initiator: runs one DATI, DATO or DATOB cycle per request on the inverted, multiplexed nAD bus.
// All pin outputs are registered; nRPLY is brought into the clock domain by a two-flop synchroniser.
module qbus_master #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        PIN_CLK,
  input  logic        PIN_nRST,
  input  logic        req,
  input  logic        we,
  input  logic        byte_wr,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] PIN_nAD_out,
  output logic        PIN_nAD_oe,
  input  logic [15:0] PIN_nAD_in,
  output logic        PIN_nSYNC,
  output logic        PIN_nDIN,
  output logic        PIN_nDOUT,
  output logic        PIN_nWTBT,
  input  logic        PIN_nRPLY,
  output logic [2:0]  dbg_state
);

  // Client handshake: req is looked at only while idle; acceptance is visible as busy
  // rising. ack is a one-clock pulse with err valid alongside it, and busy is already low.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADR    = 3'd1,
    S_AHLD   = 3'd2,
    S_DSET   = 3'd3,
    S_WRPLY  = 3'd4,
    S_TERM   = 3'd5,
    S_WNRPLY = 3'd6,
    S_REL    = 3'd7
  } state_e;

  localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT);

  state_e        st_q, st_d;
  logic          we_q, we_d;
  logic          byte_q, byte_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [15:0]   nad_out_q, nad_out_d;
  logic          nad_oe_q, nad_oe_d;
  logic          nsync_q, nsync_d;
  logic          ndin_q, ndin_d;
  logic          ndout_q, ndout_d;
  logic          nwtbt_q, nwtbt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          rply;

  assign rply = ~sync2_q;

  always_comb begin
    st_d      = st_q;
    we_d      = we_q;
    byte_d    = byte_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    sync1_d   = PIN_nRPLY;
    sync2_d   = sync1_q;
    nad_out_d = nad_out_q;
    nad_oe_d  = nad_oe_q;
    nsync_d   = nsync_q;
    ndin_d    = ndin_q;
    ndout_d   = ndout_q;
    nwtbt_d   = nwtbt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;

    case (st_q)
      S_IDLE: begin
        if (req) begin
          we_d      = we;
          byte_d    = byte_wr;
          wdata_d   = wdata;
          nad_out_d = ~addr;
          nad_oe_d  = 1'b1;
          nwtbt_d   = ~we;
          st_d      = S_ADR;
        end
      end
      S_ADR: begin
        nsync_d = 1'b0;
        st_d    = S_AHLD;
      end
      S_AHLD: begin
        cnt_d = '0;
        if (we_q) begin
          nad_out_d = ~wdata_q;
          nwtbt_d   = ~byte_q;
          st_d      = S_DSET;
        end else begin
          // Turn the bus around in the same clock DIN asserts so the responder can drive it.
          nad_oe_d = 1'b0;
          nwtbt_d  = 1'b1;
          ndin_d   = 1'b0;
          st_d     = S_WRPLY;
        end
      end
      S_DSET: begin
        ndout_d = 1'b0;
        cnt_d   = '0;
        st_d    = S_WRPLY;
      end
      S_WRPLY: begin
        if (rply) begin
          cnt_d = '0;
          st_d  = S_TERM;
        end else if (cnt_q == TO_CNT) begin
          cnt_d   = '0;
          abort_d = 1'b1;
          st_d    = S_TERM;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_TERM: begin
        if (!we_q && !abort_q) begin
          rdata_d = ~PIN_nAD_in;
        end
        nsync_d = 1'b1;
        ndin_d  = 1'b1;
        ndout_d = 1'b1;
        cnt_d   = '0;
        st_d    = abort_q ? S_REL : S_WNRPLY;
      end
      S_WNRPLY: begin
        if (!rply) begin
          cnt_d = '0;
          st_d  = S_REL;
        end else if (cnt_q == TO_CNT) begin
          cnt_d   = '0;
          abort_d = 1'b1;
          st_d    = S_REL;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_REL: begin
        nad_oe_d  = 1'b0;
        nad_out_d = 16'hFFFF;
        nwtbt_d   = 1'b1;
        ack_d     = 1'b1;
        err_d     = abort_q;
        abort_d   = 1'b0;
        st_d      = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PIN_CLK) begin
    if (!PIN_nRST) begin
      st_q      <= S_IDLE;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      nad_out_q <= 16'hFFFF;
      nad_oe_q  <= 1'b0;
      nsync_q   <= 1'b1;
      ndin_q    <= 1'b1;
      ndout_q   <= 1'b1;
      nwtbt_q   <= 1'b1;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      st_q      <= st_d;
      we_q      <= we_d;
      byte_q    <= byte_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      nad_out_q <= nad_out_d;
      nad_oe_q  <= nad_oe_d;
      nsync_q   <= nsync_d;
      ndin_q    <= ndin_d;
      ndout_q   <= ndout_d;
      nwtbt_q   <= nwtbt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = (st_q != S_IDLE);
  assign PIN_nAD_out = nad_out_q;
  assign PIN_nAD_oe  = nad_oe_q;
  assign PIN_nSYNC   = nsync_q;
  assign PIN_nDIN    = ndin_q;
  assign PIN_nDOUT   = ndout_q;
  assign PIN_nWTBT   = nwtbt_q;
  assign dbg_state   = st_q;

endmodule

// File: tb/tb_qbus_master.sv
// Bench for qbus_master: a Q-bus responder with its own memory, a transaction-level reference
// memory producing the expected ack/err/rdata, and a monitor checking bus ordering and timing.
module tb_qbus_master;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req = 1'b0, we = 1'b0, byte_wr = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic        ack, err, busy;
  logic [15:0] rdata, nad_out;
  logic        nad_oe, nsync, ndin, ndout, nwtbt;
  logic [15:0] nad_in = 16'hFFFF;
  logic        nrply = 1'b1;
  logic [2:0]  dbg_state;

  qbus_master #(.TIMEOUT(TIMEOUT), .TW(7)) dut (
    .PIN_CLK(clk), .PIN_nRST(nrst), .req(req), .we(we), .byte_wr(byte_wr),
    .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .PIN_nAD_out(nad_out), .PIN_nAD_oe(nad_oe), .PIN_nAD_in(nad_in),
    .PIN_nSYNC(nsync), .PIN_nDIN(ndin), .PIN_nDOUT(ndout), .PIN_nWTBT(nwtbt),
    .PIN_nRPLY(nrply), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0, failures = 0;
  logic [16:0] exp_q[$];       // {err, rdata} per completed cycle
  logic [33:0] exp_bus_q[$];   // {we, byte, addr, wdata} per started cycle
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] resp_mem[logic [15:0]];
  logic [15:0] last_rd = '0;
  int acks = 0, starts = 0;
  bit resp_no_reply = 0;
  int resp_delay = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input bit b, input bit odd);
    if (!b) return d;
    return odd ? {d[15:8], old[7:0]} : {old[15:8], d[7:0]};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    logic [15:0] k = a & 16'hFFFE;
    return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
  endfunction

  function automatic logic [15:0] resp_rd(input logic [15:0] a);
    logic [15:0] k = a & 16'hFFFE;
    return resp_mem.exists(k) ? resp_mem[k] : 16'h0000;
  endfunction

  // Reference model: what a completed transaction must return, from the bus protocol rules only.
  task automatic push_expect(input bit w, input bit b, input logic [15:0] a,
                             input logic [15:0] d, input bit noreply, input bit with_ack);
    logic [15:0] k = a & 16'hFFFE;
    exp_bus_q.push_back({w, b, a, d});
    if (!noreply) begin
      if (w) ref_mem[k] = merge(ref_rd(a), d, b, a[0]);
      else   last_rd = ref_rd(a);
    end
    if (with_ack) exp_q.push_back({noreply, last_rd});
  endtask

  // ---------------- monitor + responder ----------------
  logic [33:0] cur;
  logic [15:0] cur_addr = '0;
  initial begin
    bit prev_nsync = 1, prev_strobe = 0, prev_ack = 0, prev_busy = 0, strobe;
    int hi_run = 0, rcnt = 0, strobe_cyc = 0;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      strobe = !ndin || !ndout;
      check("din_dout_excl", {31'd0, !ndin && !ndout}, 0);
      check("oe_while_din", {31'd0, nad_oe && !ndin}, 0);
      if (busy && !prev_busy) starts++;
      if (prev_nsync && !nsync) begin
        check("sync_gap_ge2", {31'd0, hi_run >= 2}, 1);
        check("sync_fall_oe", {31'd0, nad_oe}, 1);
        if (exp_bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cycle: nSYNC fell with no cycle issued");
          cur = '0;
        end else cur = exp_bus_q.pop_front();
        cur_addr = cur[31:16];
        check("addr_phase_nad", {16'd0, nad_out}, {16'd0, ~cur[31:16]});
        check("addr_phase_wtbt", {31'd0, nwtbt}, {31'd0, ~cur[33]});
      end
      hi_run = nsync ? hi_run + 1 : 0;
      if (strobe && !prev_strobe) begin
        strobe_cyc = cyc;
        if (cur[33]) begin
          check("data_phase_nad", {16'd0, nad_out}, {16'd0, ~cur[15:0]});
          check("data_phase_wtbt", {31'd0, nwtbt}, {31'd0, ~cur[32]});
          check("data_phase_oe", {31'd0, nad_oe}, 1);
        end else begin
          check("read_ndout_high", {31'd0, ndout}, 1);
          check("read_oe_off", {31'd0, nad_oe}, 0);
          check("read_wtbt_high", {31'd0, nwtbt}, 1);
        end
      end
      if (ack) begin
        acks++;
        check("ack_one_clock", {31'd0, prev_ack}, 0);
        check("ack_idle_pins", {27'd0, nad_oe, nwtbt, nsync, ndin, ndout}, 32'b01111);
        check("ack_busy_low", {31'd0, busy}, 0);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: ack with nothing outstanding err=%b", err);
        end else begin
          e = exp_q.pop_front();
          check("ack_err", {31'd0, err}, {31'd0, e[16]});
          check("ack_rdata", {16'd0, rdata}, {16'd0, e[15:0]});
          if (e[16]) check("timeout_latency", cyc - strobe_cyc, TIMEOUT + 3);
        end
      end
      prev_nsync = nsync; prev_strobe = strobe; prev_ack = ack; prev_busy = busy;
      // Responder: reply resp_delay clocks into the strobe, release as soon as strobes rise.
      if (strobe) begin
        rcnt++;
        if (!resp_no_reply && rcnt == resp_delay) begin
          if (!ndout)
            resp_mem[cur_addr & 16'hFFFE] = merge(resp_rd(cur_addr), ~nad_out, !nwtbt, cur_addr[0]);
          else
            nad_in = ~resp_rd(cur_addr);
          nrply = 1'b0;
        end
      end else begin
        rcnt = 0;
        nrply = 1'b1;
        nad_in = 16'hFFFF;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acks(input int target, input string name);
    int n = 0;
    while (acks < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (acks < target) check({name, "_ack_timeout"}, acks, target);
  endtask

  task automatic issue(input bit w, input bit b, input logic [15:0] a, input logic [15:0] d,
                       input bit noreply, input int dly);
    int target = acks + 1;
    push_expect(w, b, a, d, noreply, 1);
    resp_no_reply = noreply;
    resp_delay = dly;
    req = 1'b1; we = w; byte_wr = b; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    we = 1'($urandom); byte_wr = 1'($urandom);
    addr = 16'($urandom); wdata = 16'($urandom);
    wait_acks(target, "issue");
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic b2b_reads(input logic [15:0] a);
    int s0 = starts, target = acks + 3, n = 0;
    for (int i = 0; i < 3; i++) push_expect(0, 0, a, 16'h0, 0, 1);
    resp_no_reply = 0;
    resp_delay = 2;
    req = 1'b1; we = 1'b0; byte_wr = 1'b0; addr = a;
    while (starts < s0 + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    check("b2b_starts", starts - s0, 3);
    wait_acks(target, "b2b");
  endtask

  task automatic reset_mid_write(input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    push_expect(1, 0, a, d, 1, 0);
    resp_no_reply = 1;
    req = 1'b1; we = 1'b1; byte_wr = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    while (ndout && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_reached_wrply", {31'd0, ndout}, 0);
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    last_rd = 16'h0000;
    check("rst_mid_pins", {27'd0, nsync, ndin, ndout, nwtbt, nad_oe}, 32'b11110);
    check("rst_mid_nad", {16'd0, nad_out}, 32'h0000FFFF);
    check("rst_mid_status", {29'd0, busy, ack, err}, 0);
    check("rst_mid_rdata", {16'd0, rdata}, 0);
    check("rst_mid_state", {29'd0, dbg_state}, 0);
    repeat (10) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (4) @(negedge clk);
    check("rst_pins", {27'd0, nsync, ndin, ndout, nwtbt, nad_oe}, 32'b11110);
    check("rst_nad", {16'd0, nad_out}, 32'h0000FFFF);
    check("rst_status", {29'd0, busy, ack, err}, 0);
    check("rst_rdata", {16'd0, rdata}, 0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    issue(1, 0, 16'o177664, 16'o000330, 0, 3);
    issue(1, 0, 16'o000010, 16'o000015, 0, 2);
    issue(0, 0, 16'o000010, 16'h0, 0, 4);
    issue(1, 1, 16'o000001, 16'o000377, 0, 1);
    issue(0, 0, 16'o000000, 16'h0, 0, 2);
    issue(0, 0, 16'o000010, 16'h0, 1, 1);
    issue(1, 0, 16'o000020, 16'o123456, 1, 1);
    reset_mid_write(16'o000020, 16'o007070);
    issue(1, 0, 16'o000020, 16'o054321, 0, 2);
    issue(0, 0, 16'o000020, 16'h0, 0, 3);
    b2b_reads(16'o000010);

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 1'($urandom), 16'o001000 + 16'($urandom_range(0, 15)),
            16'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(1, 6));
    end
    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
